dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Requester/responder bus for dmem_responder.
//   req_valid/req_ready : request handshake, accepted when both are high on a rising edge
//   req_write/req_byte  : store (1) or load (0); byte (1) or word (0) access
//   req_addr/req_wdata  : 12-bit byte address, store data (byte stores use [7:0])
//   resp_valid          : one-cycle completion pulse
//   resp_rdata/resp_err : load data and fault flag, meaningful only with resp_valid
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: a word-organised, byte-addressed memory with a fixed-latency
// single-outstanding-request handshake.
//   clk_i   : clock, all state changes on the rising edge
//   reset_i : synchronous active-high reset (memory contents are kept)
//   bus     : request/response bus (slave side)
//   busy_o  : a request is in flight
module dmem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,    // 0..15
    parameter int unsigned DEPTH_WORDS = 1024  // 1..1024
) (
    input  logic              clk_i,
    input  logic              reset_i,
    dmem_responder_if.slave   bus,
    output logic              busy_o
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        byte_q, byte_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [9:0]      word_idx;
    logic [1:0]      lane;
    logic [IdxW-1:0] mem_idx;
    logic            misaligned;
    logic            out_of_range;
    logic            fault;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shift;
    logic [31:0]     load_data;
    logic [31:0]     wr_word;
    logic            commit;
    logic            in_resp;

    // Next-state logic. WAIT spans WAIT_CYCLES+1 cycles (counter runs down to zero), so a
    // request accepted at edge N enters RESP at edge N+WAIT_CYCLES+1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    state_d = StWait;
                    cnt_d   = 4'(WAIT_CYCLES);
                    write_d = bus.req_write;
                    byte_d  = bus.req_byte;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= 12'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Address decode of the captured request.
    always_comb begin
        word_idx     = addr_q[11:2];
        lane         = addr_q[1:0];
        mem_idx      = word_idx[IdxW-1:0];
        misaligned   = !byte_q && (lane != 2'd0);
        out_of_range = (32'(word_idx) >= DEPTH_WORDS);
        fault        = misaligned || out_of_range;
    end

    // Read path and byte-merge for stores (little-endian lanes).
    always_comb begin
        rd_word  = out_of_range ? 32'd0 : mem_q[mem_idx];
        rd_shift = rd_word >> {lane, 3'b000};
        if (byte_q) begin
            load_data = {24'd0, rd_shift[7:0]};
        end else begin
            load_data = rd_word;
        end
        wr_word = rd_word;
        if (byte_q) begin
            wr_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            wr_word = wdata_q;
        end
    end

    // Stores land on the edge that enters RESP; a reset on that edge aborts them.
    assign commit = !reset_i && (state_q == StWait) && (cnt_q == 4'd0) && write_q && !fault;

    always_ff @(posedge clk_i) begin
        if (commit) begin
            mem_q[mem_idx] <= wr_word;
        end
    end

    // Outputs are all zero outside RESP.
    always_comb begin
        in_resp        = (state_q == StResp);
        bus.req_ready  = (state_q == StIdle);
        busy_o         = (state_q != StIdle);
        bus.resp_valid = in_resp;
        bus.resp_err   = in_resp && fault;
        bus.resp_rdata = (in_resp && !fault && !write_q) ? load_data : 32'd0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2/1024-word instance (A) and a
// WAIT_CYCLES=0/512-word instance (B), sharing clock and reset.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;  // 0 = instance A, 1 = instance B
    logic        d_valid = 1'b0;
    logic        d_write = 1'b0;
    logic        d_byte = 1'b0;
    logic [11:0] d_addr = 12'd0;
    logic [31:0] d_wdata = 32'd0;

    int tests = 0;
    int fails = 0;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();
    logic busy_a, busy_b;

    assign bus_a.req_valid = d_valid && !sel;
    assign bus_a.req_write = d_write;
    assign bus_a.req_byte  = d_byte;
    assign bus_a.req_addr  = d_addr;
    assign bus_a.req_wdata = d_wdata;
    assign bus_b.req_valid = d_valid && sel;
    assign bus_b.req_write = d_write;
    assign bus_b.req_byte  = d_byte;
    assign bus_b.req_addr  = d_addr;
    assign bus_b.req_wdata = d_wdata;

    dmem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(1024)) dut_a (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus_a),
        .busy_o  (busy_a)
    );

    dmem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(512)) dut_b (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus_b),
        .busy_o  (busy_b)
    );

    logic        o_ready, o_valid, o_err, o_busy;
    logic [31:0] o_rdata;
    assign o_ready = sel ? bus_b.req_ready  : bus_a.req_ready;
    assign o_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
    assign o_err   = sel ? bus_b.resp_err   : bus_a.resp_err;
    assign o_rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
    assign o_busy  = sel ? busy_b           : busy_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ":ready"}, 32'(o_ready), 32'd1);
        check({tag, ":busy"},  32'(o_busy),  32'd0);
        check({tag, ":valid"}, 32'(o_valid), 32'd0);
        check({tag, ":err"},   32'(o_err),   32'd0);
        check({tag, ":rdata"}, o_rdata,      32'd0);
    endtask

    // One request on the selected instance; w is that instance's WAIT_CYCLES.
    // Response expected in the cycle after edge N+w+1, idle again one cycle later.
    task automatic do_req(input int w, input logic wr, input logic by, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
        @(negedge clk);
        d_valid = 1'b1;
        d_write = wr;
        d_byte  = by;
        d_addr  = addr;
        d_wdata = wdata;
        check({tag, ":ready_pre"}, 32'(o_ready), 32'd1);
        @(posedge clk);
        #1 d_valid = 1'b0;
        for (int c = 1; c <= w + 3; c++) begin
            @(negedge clk);
            if (c <= w + 1) begin
                check({tag, ":wait_valid"}, 32'(o_valid), 32'd0);
                check({tag, ":wait_ready"}, 32'(o_ready), 32'd0);
                check({tag, ":wait_busy"},  32'(o_busy),  32'd1);
                check({tag, ":wait_rdata"}, o_rdata,      32'd0);
            end else if (c == w + 2) begin
                check({tag, ":resp_valid"}, 32'(o_valid), 32'd1);
                check({tag, ":resp_ready"}, 32'(o_ready), 32'd0);
                check({tag, ":resp_err"},   32'(o_err),   32'(exp_err));
                check({tag, ":resp_rdata"}, o_rdata,      exp_rdata);
            end else begin
                check_idle({tag, ":after"});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        sel = 1'b0;
        #1 check_idle("rst_a");
        sel = 1'b1;
        #1 check_idle("rst_b");
        sel = 1'b0;

        // Instance A, WAIT_CYCLES=2
        do_req(2, 1'b1, 1'b0, 12'h0A8, 32'h11223344, 32'h0, 1'b0, "st_w_0a8");
        do_req(2, 1'b0, 1'b0, 12'h0A8, 32'h0, 32'h11223344, 1'b0, "ld_w_0a8");
        do_req(2, 1'b1, 1'b1, 12'h0A9, 32'h000000EE, 32'h0, 1'b0, "st_b_0a9");
        do_req(2, 1'b0, 1'b0, 12'h0A8, 32'h0, 32'h1122EE44, 1'b0, "ld_w_merge");
        do_req(2, 1'b0, 1'b1, 12'h0AB, 32'h0, 32'h00000011, 1'b0, "ld_b_0ab");
        do_req(2, 1'b0, 1'b1, 12'h0AA, 32'h0, 32'h00000022, 1'b0, "ld_b_0aa");
        do_req(2, 1'b0, 1'b0, 12'h0AA, 32'h0, 32'h0, 1'b1, "ld_w_misal");
        do_req(2, 1'b1, 1'b0, 12'h0AA, 32'hFFFFFFFF, 32'h0, 1'b1, "st_w_misal");
        do_req(2, 1'b0, 1'b0, 12'h0A8, 32'h0, 32'h1122EE44, 1'b0, "ld_w_unchanged");
        do_req(2, 1'b1, 1'b0, 12'h010, 32'h0BADF00D, 32'h0, 1'b0, "st_w_010");

        // Reset one cycle after accepting a store aborts it
        @(negedge clk);
        d_valid = 1'b1; d_write = 1'b1; d_byte = 1'b0;
        d_addr = 12'h010; d_wdata = 32'hDEADBEEF;
        check("abort:ready_pre", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1 d_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort:busy_before_reset", 32'(o_busy), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abort:no_valid", 32'(o_valid), 32'd0);
            check("abort:idle_busy", 32'(o_busy), 32'd0);
        end
        do_req(2, 1'b0, 1'b0, 12'h010, 32'h0, 32'h0BADF00D, 1'b0, "ld_after_abort");

        // Reset beats a simultaneous request
        @(negedge clk);
        reset = 1'b1;
        d_valid = 1'b1; d_write = 1'b0; d_byte = 1'b0; d_addr = 12'h010;
        @(posedge clk);
        #1 reset = 1'b0;
        d_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_idle("rst_vs_req");
        end

        // Back-to-back with req_valid held high: cycles c=1..10 after acceptance edge N
        @(negedge clk);
        d_valid = 1'b1; d_write = 1'b0; d_byte = 1'b0; d_addr = 12'h0A8;
        @(posedge clk);
        #1 d_byte = 1'b1;
        d_addr = 12'h0AB;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("b2b:ready", 32'(o_ready), 32'((c == 5) || (c == 10)));
            check("b2b:busy",  32'(o_busy),  32'(!((c == 5) || (c == 10))));
            check("b2b:valid", 32'(o_valid), 32'((c == 4) || (c == 9)));
            if (c == 4) check("b2b:rdata1", o_rdata, 32'h1122EE44);
            if (c == 9) check("b2b:rdata2", o_rdata, 32'h00000011);
            if (c == 5) begin
                @(posedge clk);
                #1 d_valid = 1'b0;
            end
        end

        // Instance B, WAIT_CYCLES=0, 512 words
        @(negedge clk);
        sel = 1'b1;
        do_req(0, 1'b1, 1'b0, 12'h004, 32'hCAFEF00D, 32'h0, 1'b0, "b_st_w_004");
        do_req(0, 1'b0, 1'b0, 12'h004, 32'h0, 32'hCAFEF00D, 1'b0, "b_ld_w_004");
        do_req(0, 1'b0, 1'b1, 12'h006, 32'h0, 32'h000000FE, 1'b0, "b_ld_b_006");
        do_req(0, 1'b1, 1'b0, 12'h800, 32'h12345678, 32'h0, 1'b1, "b_st_oob");
        do_req(0, 1'b0, 1'b0, 12'h800, 32'h0, 32'h0, 1'b1, "b_ld_oob");
        do_req(0, 1'b0, 1'b0, 12'h004, 32'h0, 32'hCAFEF00D, 1'b0, "b_ld_w_004_again");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
